uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first. It implements the receive half of the board UART and is instantiated beside the transmitter, which already drives `Tx`. It recovers bytes from the `Rx` pin, presents each one on `O_DATA` and flags it with a one-cycle `NrD` pulse. It uses the same `BAUD_DIVIDER` value as the transmitter, so a loopback link runs at matching rates.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding and frame constants.
// The transmitter imports the same frame constants so both halves agree on the frame shape.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        RX_BREAK = 3'd0,
        RX_IDLE  = 3'd1,
        RX_START = 3'd2,
        RX_DATA  = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    function automatic logic rx_busy(input rx_state_t s);
        return (s == RX_START) || (s == RX_DATA) || (s == RX_STOP);
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin.
// The reset value is a parameter so idle-high and idle-low pins can both use it.
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= INIT;
            r_q    <= INIT;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: samples each bit once at mid-bit on the synchronized line
// and reports good bytes with NrD and bad stop bits with FrE.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD_DIVIDER = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    output logic [7:0] O_DATA,
    output logic       NrD,
    output logic       FrE,
    output logic       RiP
);

    localparam int HALF = BAUD_DIVIDER >> 1;
    localparam int CW   = $clog2(BAUD_DIVIDER);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIVIDER - 1);
    localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic          w_rx_s;
    rx_state_t     r_state,   w_state_nxt;
    logic [CW-1:0] r_cnt,     w_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [7:0]    r_shift,   w_shift_nxt;
    logic [7:0]    r_data,    w_data_nxt;
    logic          r_nrd,     w_nrd_nxt;
    logic          r_fre,     w_fre_nxt;
    logic          r_rip,     w_rip_nxt;
    logic [1:0]    r_sync_ok;

    sync_2ff #(.INIT(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (Rx),
        .o_q (w_rx_s)
    );

    // The synchronizer resets high, so rx_s is not trustworthy until both
    // flops have refilled from the pin; BREAK must not exit on that reset value.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignment so every flop
        // samples the values present before the edge, independent of statement order.
        if (rst) begin
            r_state   <= RX_BREAK;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_nrd     <= 1'b0;
            r_fre     <= 1'b0;
            r_rip     <= 1'b0;
            r_sync_ok <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_nrd     <= w_nrd_nxt;
            r_fre     <= w_fre_nxt;
            r_rip     <= w_rip_nxt;
            r_sync_ok <= {r_sync_ok[0], 1'b1};
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        unique case (r_state)
            RX_BREAK: begin
                if (w_rx_s && r_sync_ok[1]) w_state_nxt = RX_IDLE;
            end
            RX_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (r_cnt == CNT_HALF) begin
                    if (!w_rx_s) begin
                        w_state_nxt   = RX_DATA;
                        w_cnt_nxt     = '0;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = RX_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {w_rx_s, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == BIT_LAST) w_state_nxt = RX_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = w_rx_s ? RX_IDLE : RX_BREAK;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = RX_BREAK;
        endcase
    end

    // Next values of the registered outputs, derived from the stop-bit sample.
    always_comb begin
        w_nrd_nxt  = (r_state == RX_STOP) && (r_cnt == CNT_LAST) && w_rx_s;
        w_fre_nxt  = (r_state == RX_STOP) && (r_cnt == CNT_LAST) && !w_rx_s;
        w_data_nxt = w_nrd_nxt ? r_shift : r_data;
        w_rip_nxt  = rx_busy(w_state_nxt);
    end

    assign O_DATA = r_data;
    assign NrD    = r_nrd;
    assign FrE    = r_fre;
    assign RiP    = r_rip;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver queues each good byte it sends and a
// negedge monitor pops and compares whenever NrD pulses.
module tb_uart_rx;

    localparam int BD   = 9;
    localparam int HALF = BD >> 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] o_data;
    logic       nrd;
    logic       fre;
    logic       rip;

    uart_rx #(.BAUD_DIVIDER(BD)) dut (
        .clk    (clk),
        .rst    (rst),
        .Rx     (rx),
        .O_DATA (o_data),
        .NrD    (nrd),
        .FrE    (fre),
        .RiP    (rip)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int nrd_count    = 0;
    int fre_count    = 0;
    int rip_hi       = 0;
    int last_nrd_cyc = 0;
    int prev_nrd_cyc = 0;
    int frame_start  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every NrD pulse, tallies FrE and RiP.
    always @(negedge clk) begin
        if (!rst) begin
            if (nrd) begin
                nrd_count++;
                prev_nrd_cyc = last_nrd_cyc;
                last_nrd_cyc = cyc;
                if (exp_q.size() == 0) check("spurious_nrd", 32'(nrd), 32'd0);
                else                   check("rx_byte", 32'(o_data), 32'(exp_q.pop_front()));
            end
            if (fre) fre_count++;
            if (rip) rip_hi++;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge; good frames go to the scoreboard.
    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        if (stop_v) exp_q.push_back(d);
        rx = 1'b0;
        frame_start = cyc + 1;
        hold(BD);
        for (int k = 0; k < 8; k++) begin
            rx = d[k];
            hold(BD);
        end
        rx = stop_v;
        hold(BD);
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, f0, r0;
        rx  = 1'b1;
        rst = 1'b1;
        hold(4);
        check("reset_o_data", 32'(o_data), 32'h00);
        check("reset_nrd", 32'(nrd), 32'd0);
        check("reset_fre", 32'(fre), 32'd0);
        check("reset_rip", 32'(rip), 32'd0);
        rst = 1'b0;
        hold(10);

        // Single frame: latency from first low sample to stop sample is 2+HALF+9*BD = 87.
        f0 = fre_count;
        send_frame(8'hA5, 1'b1);
        check("a5_latency", 32'(last_nrd_cyc - frame_start), 32'(2 + HALF + 9 * BD));
        check("a5_nrd_count", 32'(nrd_count), 32'd1);
        check("a5_no_fre", 32'(fre_count - f0), 32'd0);
        hold(2 * BD);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        check("b2b_spacing", 32'(last_nrd_cyc - prev_nrd_cyc), 32'(10 * BD));
        check("b2b_nrd_count", 32'(nrd_count), 32'd3);
        hold(BD);

        // Two-cycle low glitch on an idle line.
        n0 = nrd_count; f0 = fre_count; r0 = rip_hi;
        rx = 1'b0;
        hold(2);
        rx = 1'b1;
        hold(3 * BD);
        check("glitch_rip_len", 32'((rip_hi - r0) >= 1 && (rip_hi - r0) <= HALF + 1), 32'd1);
        check("glitch_no_nrd", 32'(nrd_count - n0), 32'd0);
        check("glitch_no_fre", 32'(fre_count - f0), 32'd0);
        check("glitch_o_data", 32'(o_data), 32'hFF);

        // Bad stop bit, then break for 3 bit times, then recovery with 0x11.
        n0 = nrd_count; f0 = fre_count;
        send_frame(8'h3C, 1'b0);
        hold(3 * BD);
        rx = 1'b1;
        hold(2 * BD);
        check("frame_err_fre_once", 32'(fre_count - f0), 32'd1);
        check("frame_err_no_nrd", 32'(nrd_count - n0), 32'd0);
        check("frame_err_o_data", 32'(o_data), 32'hFF);
        send_frame(8'h11, 1'b1);
        hold(5);
        check("recover_o_data", 32'(o_data), 32'h11);

        // Reset during data bit 4 with the line still low at release.
        rx = 1'b0;
        hold(BD);
        hold(4 * BD);
        hold(BD / 2);
        rst = 1'b1;
        hold(3);
        check("midreset_o_data", 32'(o_data), 32'h00);
        check("midreset_rip", 32'(rip), 32'd0);
        rst = 1'b0;
        n0 = nrd_count; f0 = fre_count; r0 = rip_hi;
        hold(3 * BD);
        check("post_reset_no_rip", 32'(rip_hi - r0), 32'd0);
        check("post_reset_no_nrd", 32'(nrd_count - n0), 32'd0);
        check("post_reset_no_fre", 32'(fre_count - f0), 32'd0);
        check("post_reset_o_data", 32'(o_data), 32'h00);
        rx = 1'b1;
        hold(2 * BD);
        send_frame(8'h5A, 1'b1);
        hold(5);
        check("post_reset_5a", 32'(o_data), 32'h5A);

        // Continuous stream of every byte value, as a transmitter loopback would send.
        n0 = nrd_count; f0 = fre_count;
        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
        hold(BD);
        check("stream_nrd_count", 32'(nrd_count - n0), 32'd256);
        check("stream_no_fre", 32'(fre_count - f0), 32'd0);

        for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
